dir_button_ctrl: RTL and testbench

Conditions the raw MAX1000 user push-button into the clean `dir` control bit for the downstream 3-bit direction state machine. It performs a 2-flop synchronisation of the asynchronous pin, then a counter-based debounce FSM. It outputs a debounced level, a single-cycle press strobe, and a `dir` bit that either toggles per press or follows the button level. Sits directly between the board pin and the state machine's `dir` input, in the same clock domain.

---
 rtl/dir_button_pkg.sv | 17 +
 rtl/sync_2ff.sv | 27 ++
 rtl/dir_button_ctrl.sv | 115 +++++++++++
 tb/tb_dir_button_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/dir_button_pkg.sv
// dir_button_pkg: shared state encoding for the push-button debounce FSM
package dir_button_pkg;

   typedef enum logic [1:0] {
      ST_RELEASED     = 2'd0,
      ST_PRESS_PEND   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_RELEASE_PEND = 2'd3
   } btn_state_t;

   // The debounced level is high while the press is accepted, including
   // while a release is still being qualified.
   function automatic logic is_held(input btn_state_t s);
      return (s == ST_PRESSED) || (s == ST_RELEASE_PEND);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous board pin
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   // Shift the pin through two flops; reset loads the idle level of the pin.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/dir_button_ctrl.sv
// dir_button_ctrl: synchronise and debounce the user button into the dir bit
module dir_button_ctrl
   import dir_button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter bit DIR_MODE        = 1'b0,
   localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic dir,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             btn_sync;
   logic             btn_s;
   btn_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             pressed_q, pressed_d;
   logic             press_pulse_q, press_pulse_d;
   logic             release_pulse_q, release_pulse_d;

   // The pin idles high (released), so the synchroniser resets to 1.
   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn_n),
      .q   (btn_sync)
   );

   assign btn_s = ~btn_sync;

   // Debounce FSM: a level must hold for DEBOUNCE_CYCLES samples to be accepted.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_RELEASED: begin
            if (btn_s) begin
               state_d = ST_PRESS_PEND;
               cnt_d   = '0;
            end
         end
         ST_PRESS_PEND: begin
            if (!btn_s) begin
               state_d = ST_RELEASED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_PRESSED;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_PRESSED: begin
            if (!btn_s) begin
               state_d = ST_RELEASE_PEND;
               cnt_d   = '0;
            end
         end
         ST_RELEASE_PEND: begin
            if (btn_s) begin
               state_d = ST_PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_RELEASED;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are derived from the next state so they register on the accepting edge.
   always_comb begin
      pressed_d       = is_held(state_d);
      press_pulse_d   = (state_q == ST_PRESS_PEND) && (state_d == ST_PRESSED);
      release_pulse_d = (state_q == ST_RELEASE_PEND) && (state_d == ST_RELEASED);
      dir_d           = DIR_MODE ? pressed_d : dir_q ^ press_pulse_d;
   end

   // State, counter and output registers; reset aborts any pending qualification.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= ST_RELEASED;
         cnt_q           <= '0;
         dir_q           <= 1'b0;
         pressed_q       <= 1'b0;
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         dir_q           <= dir_d;
         pressed_q       <= pressed_d;
         press_pulse_q   <= press_pulse_d;
         release_pulse_q <= release_pulse_d;
      end
   end

   assign dir           = dir_q;
   assign pressed       = pressed_q;
   assign press_pulse   = press_pulse_q;
   assign release_pulse = release_pulse_q;

endmodule

// File: tb/tb_dir_button_ctrl.sv
// tb_dir_button_ctrl: table-driven check of both dir modes with DEBOUNCE_CYCLES=4
module tb_dir_button_ctrl;

   typedef struct {
      logic btn_n;
      logic rst;
      logic dir0;
      logic dir1;
      logic pressed;
      logic pp;
      logic rp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic btn_n = 1'b1;
   logic dir0, pressed0, pp0, rp0;
   logic dir1, pressed1, pp1, rp1;

   vec_t vq[$];
   logic d;
   int   n_vec = 0;
   int   n_bad = 0;

   always #2 clk = ~clk;

   dir_button_ctrl #(.DEBOUNCE_CYCLES(4), .DIR_MODE(1'b0)) u_m0 (
      .clk           (clk),
      .rst           (rst),
      .btn_n         (btn_n),
      .dir           (dir0),
      .pressed       (pressed0),
      .press_pulse   (pp0),
      .release_pulse (rp0)
   );

   dir_button_ctrl #(.DEBOUNCE_CYCLES(4), .DIR_MODE(1'b1)) u_m1 (
      .clk           (clk),
      .rst           (rst),
      .btn_n         (btn_n),
      .dir           (dir1),
      .pressed       (pressed1),
      .press_pulse   (pp1),
      .release_pulse (rp1)
   );

   task automatic push(input int n, input logic b, input logic r, input logic dv,
                       input logic p, input logic pp, input logic rp);
      vec_t v;
      v.btn_n = b; v.rst = r; v.dir0 = dv; v.dir1 = p; v.pressed = p; v.pp = pp; v.rp = rp;
      for (int i = 0; i < n; i++) vq.push_back(v);
   endtask

   // Press held n>=7 cycles from idle: accepted on the 7th edge, dir toggles there.
   task automatic press_seg(input int n);
      push(6, 1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
      d = ~d;
      push(1, 1'b0, 1'b1, d, 1'b1, 1'b1, 1'b0);
      push(n - 7, 1'b0, 1'b1, d, 1'b1, 1'b0, 1'b0);
   endtask

   // Release held n>=7 cycles from pressed: accepted on the 7th edge.
   task automatic release_seg(input int n);
      push(6, 1'b1, 1'b1, d, 1'b1, 1'b0, 1'b0);
      push(1, 1'b1, 1'b1, d, 1'b0, 1'b0, 1'b1);
      push(n - 7, 1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check(input string tag, input int idx, input vec_t v);
      n_vec++;
      if (dir0 !== v.dir0 || dir1 !== v.dir1 || pressed0 !== v.pressed || pressed1 !== v.pressed ||
          pp0 !== v.pp || pp1 !== v.pp || rp0 !== v.rp || rp1 !== v.rp) begin
         n_bad++;
         $display("FAIL %s #%0d: got dir0=%b dir1=%b pressed=%b/%b pp=%b/%b rp=%b/%b, want dir0=%b dir1=%b pressed=%b pp=%b rp=%b",
                  tag, idx, dir0, dir1, pressed0, pressed1, pp0, pp1, rp0, rp1,
                  v.dir0, v.dir1, v.pressed, v.pp, v.rp);
      end
   endtask

   task automatic run(input string tag);
      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         btn_n = vq[i].btn_n;
         rst   = vq[i].rst;
         @(posedge clk);
         #1;
         check(tag, i, vq[i]);
      end
      vq.delete();
   endtask

   initial begin
      vec_t z;
      d = 1'b0;
      // Reset with the button held, then re-qualify the held button after release.
      push(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      press_seg(10);
      release_seg(10);
      // Clean long press: dir 1 -> 0, release unaffecting dir.
      press_seg(20);
      release_seg(10);
      // Bounce: low 2 / high 1 never qualifies.
      for (int i = 0; i < 30; i++) push(1, (i % 3) == 2, 1'b1, d, 1'b0, 1'b0, 1'b0);
      push(4, 1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0);
      // Three clean presses: dir 1,0,1.
      for (int k = 0; k < 3; k++) begin
         press_seg(8);
         release_seg(8);
      end
      run("seq");
      // Mid-PRESS_PEND: four cycles of press, then asynchronous reset between edges.
      push(4, 1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
      run("pend");
      @(negedge clk);
      rst = 1'b0;
      #1;
      z.btn_n = 1'b0; z.rst = 1'b0; z.dir0 = 1'b0; z.dir1 = 1'b0;
      z.pressed = 1'b0; z.pp = 1'b0; z.rp = 1'b0;
      check("async_rst", 0, z);
      d = 1'b0;
      push(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      press_seg(10);
      release_seg(8);
      run("requal");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
